gate_bist: RTL and testbench
============================

# gate_bist

Synthesizable built-in self-test engine for any 2-input logic gate. It drives the gate's `a`/`b` inputs through all four combinations, samples the gate's `y` after a settle delay, and compares each sample against a parameterized truth table. It reports the result with a done pulse, a pass flag and a per-vector failure mask. It is the on-chip counterpart of the gate-level benches: the block that exercises a gate, rather than being exercised by one.

## Interface
- `TRUTH`, 4'b0001 (NOR): expected `y`; bit index = {a,b}, so bit0 = expected y for a=0,b=0.
- `SETTLE`, 2: cycles a vector is held before sampling; legal range 1..15.

- `clk` input 1: sole clock; everything updates on its rising edge.
- `rst` input 1: synchronous, active-high reset, applied on the rising edge of `clk`.
- `start` input 1: request a test run; accepted only in IDLE.
- `y` input 1: gate-under-test output (combinational from `a`,`b`).
- `a` output 1: gate input A; registered.
- `b` output 1: gate input B; registered.
- `busy` output 1: high from the cycle after `start` is accepted through the REPORT cycle.
- `done` output 1: one-cycle pulse; the run is complete.
- `pass` output 1: 1 iff the last completed run had zero mismatches; holds until the next start.
- `fail_mask` output 4: bit i set iff vector i={a,b} mismatched in the last run.
- `err_count` output 3: number of mismatches in the current or last run, 0..4.

## Operation
- States: IDLE, DRIVE, SAMPLE, REPORT. All outputs are registers.
- IDLE:
  - a=b=0, busy=0, done=0.
  - `start`=1 → clear idx, settle counter, fail_mask and err_count; set {a,b}=00; go to DRIVE.
- DRIVE:
  - Hold {a,b}=idx.
  - Count settle counter 0..SETTLE-1; at SETTLE-1 → SAMPLE.
- SAMPLE (1 cycle):
  - Compare `y` with TRUTH[idx].
  - On mismatch, set fail_mask[idx] and increment err_count.
  - idx<3 → idx+1, drive the new {a,b}, clear the counter, go to DRIVE.
  - idx=3 → a=b=0, go to REPORT.
- REPORT (1 cycle): done=1, busy=1, pass=(final fail_mask==0); go to IDLE.
- Vector order: 00, 01, 10, 11 ({a,b}).
- `start` is ignored outside IDLE; no queuing.
- If `start` is held high, runs repeat with exactly one IDLE cycle between REPORT and the next DRIVE.
- `rst` asserted in any state, including mid-run:
  - Next edge forces IDLE with a=b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, idx=0, counter=0.
  - No done pulse is produced for the aborted run.
- `rst` has priority over `start` on the same edge.
- fail_mask, err_count and pass persist in IDLE until the next accepted start, which clears fail_mask and err_count; pass updates only at REPORT.
- err_count saturates naturally at 4; it never wraps, since it is 3 bits wide.
- A SETTLE value outside 1..15 is a configuration error; behaviour is not defined.

## Timing
- Reset values: a=0, b=0, busy=0, done=0, pass=0, fail_mask=0000, err_count=0.
- Vector period P = SETTLE+1 cycles: SETTLE cycles in DRIVE, then 1 in SAMPLE.
- `start` sampled at edge E0:
  - Vector 0 is driven from E0.
  - Vector i is driven from edge E0+i·P.
  - `y` for vector i is sampled at edge E0+(i+1)·P.
- REPORT is entered at E0+4P: done=1 for the following cycle, deasserted at E0+4P+1.
- Default SETTLE=2: P=3 and done rises at E0+12.
- `y` must settle within SETTLE cycles of an `a`/`b` change.
- fail_mask/err_count bits become visible the edge after their SAMPLE.

## Test plan
- Ideal NOR model, TRUTH=0001, SETTLE=2, start pulse at E0 → a/b sequence 00,01,10,11 at 3-cycle spacing; done at E0+12 for exactly 1 cycle; pass=1, fail_mask=0000, err_count=0.
- OR model, TRUTH=0001 → fail_mask=1111, err_count=4, pass=0.
- AND model, TRUTH=0001 → fail_mask=1001, err_count=2, pass=0.
- Second start pulse at E0+5, mid-run → ignored; done only at E0+12. Holding start high → next run's {a,b}=00 DRIVE begins at E0+14.
- rst at E0+7 → next edge: busy=0, a=b=0, fail_mask=0, pass=0; no done appears; a fresh start then completes normally.
- SETTLE=1, NOR model → done at E0+8, pass=1; `y` forced to mismatch only during vector 10 → fail_mask=0100, err_count=1.

Source files
------------

// File: rtl/gate_bist.sv
// Built-in self-test for a 2-input gate: walks {a,b} through 00..11, samples y after SETTLE cycles,
// and compares each sample with TRUTH. Reports through done/pass/fail_mask/err_count.
module gate_bist #(
  parameter logic [3:0]  TRUTH  = 4'b0001,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_REPORT} state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE - 1);

  state_t     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_mask;
  logic [2:0] r_err;

  logic       w_mismatch;
  logic [3:0] w_mask_next;

  assign w_mismatch  = (y != TRUTH[r_idx]);
  // Mask including the vector being sampled this cycle, so pass can be decided on the last sample.
  assign w_mask_next = r_mask | (w_mismatch ? (4'b0001 << r_idx) : 4'b0000);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_cnt   <= 4'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_mask  <= 4'd0;
      r_err   <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
          r_a    <= 1'b0;
          r_b    <= 1'b0;
          if (start) begin
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_mask  <= 4'd0;
            r_err   <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_mask <= w_mask_next;
          if (w_mismatch) begin
            r_err <= r_err + 3'd1;
          end
          if (r_idx != 2'd3) begin
            r_idx      <= r_idx + 2'd1;
            {r_a, r_b} <= r_idx + 2'd1;
            r_cnt      <= 4'd0;
            r_state    <= S_DRIVE;
          end else begin
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_mask_next == 4'd0);
            r_state <= S_REPORT;
          end
        end
        S_REPORT: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_mask = r_mask;
  assign err_count = r_err;

endmodule

// File: tb/tb_gate_bist.sv
// Three BIST instances (NOR/SETTLE=2, NOR/SETTLE=1, XOR/SETTLE=3) against gate models,
// with a timeline-based reference model compared every cycle plus literal run results.
module tb_gate_bist;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_r[N];
  logic       start_r[N];
  logic       y_w[N];
  logic       a_w[N];
  logic       b_w[N];
  logic       busy_w[N];
  logic       done_w[N];
  logic       pass_w[N];
  logic [3:0] mask_w[N];
  logic [2:0] err_w[N];

  int         mode[N];      // 0 NOR, 1 OR, 2 AND, else random y
  logic       rnd[N];
  logic       fault_en[N];
  logic [1:0] fault_vec[N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  function automatic logic gate_y(input int m, input logic ia, input logic ib, input logic r);
    case (m)
      0:       return ~(ia | ib);
      1:       return ia | ib;
      2:       return ia & ib;
      default: return r;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_gate
    assign y_w[g] = gate_y(mode[g], a_w[g], b_w[g], rnd[g]) ^
                    (fault_en[g] && ({a_w[g], b_w[g]} == fault_vec[g]));
  end

  gate_bist #(.TRUTH(4'b0001), .SETTLE(2)) u_nor2 (
    .clk(clk), .rst(rst_r[0]), .start(start_r[0]), .y(y_w[0]),
    .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
    .fail_mask(mask_w[0]), .err_count(err_w[0]));

  gate_bist #(.TRUTH(4'b0001), .SETTLE(1)) u_nor1 (
    .clk(clk), .rst(rst_r[1]), .start(start_r[1]), .y(y_w[1]),
    .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
    .fail_mask(mask_w[1]), .err_count(err_w[1]));

  gate_bist #(.TRUTH(4'b0110), .SETTLE(3)) u_xor3 (
    .clk(clk), .rst(rst_r[2]), .start(start_r[2]), .y(y_w[2]),
    .a(a_w[2]), .b(b_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
    .fail_mask(mask_w[2]), .err_count(err_w[2]));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: a run is a timeline from the accepting edge E0; vector v is sampled at E0+(v+1)P.
  logic [3:0] truth_m[N];
  int         per_m[N];
  bit         run_m[N];
  bit         rep_m[N];
  int         t_m[N];
  logic       ea[N], eb[N], ebusy[N], edone[N], epass[N];
  logic [3:0] emask[N];
  logic [2:0] ecnt[N];

  initial begin
    truth_m[0] = 4'b0001; per_m[0] = 3;
    truth_m[1] = 4'b0001; per_m[1] = 2;
    truth_m[2] = 4'b0110; per_m[2] = 4;
  end

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (rst_r[i]) begin
        run_m[i] = 0; rep_m[i] = 0; t_m[i] = 0;
        ea[i] = 0; eb[i] = 0; ebusy[i] = 0; edone[i] = 0; epass[i] = 0;
        emask[i] = 4'd0; ecnt[i] = 3'd0;
      end else if (rep_m[i]) begin
        rep_m[i] = 0; edone[i] = 0; ebusy[i] = 0;
      end else if (run_m[i]) begin
        t_m[i]++;
        if (t_m[i] % per_m[i] == 0) begin
          int v;
          v = t_m[i] / per_m[i] - 1;
          if (y_w[i] !== truth_m[i][v]) begin
            emask[i][v] = 1'b1;
            ecnt[i] = ecnt[i] + 3'd1;
          end
          if (v < 3) begin
            {ea[i], eb[i]} = 2'(v + 1);
          end else begin
            ea[i] = 0; eb[i] = 0; edone[i] = 1; epass[i] = (emask[i] == 4'd0);
            run_m[i] = 0; rep_m[i] = 1;
          end
        end
      end else if (start_r[i]) begin
        run_m[i] = 1; t_m[i] = 0; emask[i] = 4'd0; ecnt[i] = 3'd0;
        ea[i] = 0; eb[i] = 0; ebusy[i] = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check($sformatf("model_u%0d", i),
              {21'd0, a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], mask_w[i], err_w[i]},
              {21'd0, ea[i], eb[i], ebusy[i], edone[i], epass[i], emask[i], ecnt[i]});
      end
    end
  end

  // Pulse start, optionally re-pulse at offset kick_at, and return edges from E0 to done (-1 on timeout).
  task automatic run(input int i, input int kick_at, output int lat);
    int e0;
    lat = -1;
    start_r[i] = 1'b1;
    @(negedge clk);
    e0 = cyc;
    for (int k = 0; k < 100; k++) begin
      start_r[i] = (cyc - e0 == kick_at - 1);
      if (i == 0 && cyc - e0 == 3) check("ab_vec1", {a_w[0], b_w[0]}, 2'b01);
      if (i == 0 && cyc - e0 == 9) check("ab_vec3", {a_w[0], b_w[0]}, 2'b11);
      if (done_w[i]) begin
        lat = cyc - e0;
        break;
      end
      @(negedge clk);
    end
    start_r[i] = 1'b0;
  endtask

  task automatic check_result(input string name, input int i, input int lat, input int exp_lat,
                              input logic exp_pass, input logic [3:0] exp_mask, input logic [2:0] exp_err);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_pass"}, pass_w[i], exp_pass);
    check({name, "_mask"}, mask_w[i], exp_mask);
    check({name, "_err"}, err_w[i], exp_err);
    @(negedge clk);
    check({name, "_done_width"}, done_w[i], 1'b0);
  endtask

  initial begin
    int lat;
    int e0;
    int rel;
    int seen;
    for (int i = 0; i < N; i++) begin
      rst_r[i] = 1'b1; start_r[i] = 1'b0; mode[i] = 0;
      rnd[i] = 1'b0; fault_en[i] = 1'b0; fault_vec[i] = 2'b00;
    end
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) rst_r[i] = 1'b0;
    check("reset_state_u0", {a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], mask_w[0], err_w[0]}, 11'd0);
    @(negedge clk);

    mode[0] = 0; run(0, -1, lat); check_result("nor", 0, lat, 12, 1'b1, 4'b0000, 3'd0);
    mode[0] = 1; run(0, -1, lat); check_result("or", 0, lat, 12, 1'b0, 4'b1111, 3'd4);
    mode[0] = 2; run(0, -1, lat); check_result("and", 0, lat, 12, 1'b0, 4'b1001, 3'd2);
    mode[0] = 0; run(0, 5, lat);  check_result("kick_mid", 0, lat, 12, 1'b1, 4'b0000, 3'd0);

    // start held high: one IDLE cycle, then the next run's first DRIVE at E0+14
    start_r[0] = 1'b1;
    @(negedge clk);
    e0 = cyc;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done_w[0]) begin lat = cyc - e0; break; end
      @(negedge clk);
    end
    check("hold_first_latency", lat, 12);
    rel = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy_w[0]) begin rel = cyc - e0; break; end
    end
    check("hold_restart_edge", rel, 14);
    check("hold_restart_ab", {a_w[0], b_w[0]}, 2'b00);
    start_r[0] = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      if (done_w[0]) begin lat = cyc - e0; break; end
      @(negedge clk);
    end
    check("hold_second_done", lat, 26);
    @(negedge clk);

    // reset sampled at E0+7 in the middle of a failing run
    mode[0] = 1;
    start_r[0] = 1'b1;
    @(negedge clk);
    e0 = cyc;
    start_r[0] = 1'b0;
    while (cyc - e0 < 6) @(negedge clk);
    rst_r[0] = 1'b1;
    @(negedge clk);
    rst_r[0] = 1'b0;
    check("rst_mid_outputs", {a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], mask_w[0], err_w[0]}, 11'd0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done_w[0]) seen++;
    end
    check("rst_no_done", seen, 0);
    mode[0] = 0; run(0, -1, lat); check_result("after_rst", 0, lat, 12, 1'b1, 4'b0000, 3'd0);

    mode[1] = 0; run(1, -1, lat); check_result("s1_nor", 1, lat, 8, 1'b1, 4'b0000, 3'd0);
    fault_en[1] = 1'b1; fault_vec[1] = 2'b10;
    run(1, -1, lat); check_result("s1_fault10", 1, lat, 8, 1'b0, 4'b0100, 3'd1);
    fault_en[1] = 1'b0;

    mode[2] = 0; run(2, -1, lat); check_result("xor_vs_nor", 2, lat, 16, 1'b0, 4'b0111, 3'd3);

    // random phase: random y, start and occasional reset on every instance
    for (int i = 0; i < N; i++) mode[i] = 3;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++) begin
        rnd[i] = 1'($urandom_range(0, 1));
        start_r[i] = ($urandom_range(0, 2) == 0);
        rst_r[i] = ($urandom_range(0, 63) == 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < N; i++) begin
      start_r[i] = 1'b0; rst_r[i] = 1'b0;
    end
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
